// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64I controller: opcodes, FSM states,
// ALU operation and ALU B-source encodings, and small decode helpers.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        HALT     = 4'd10
    } state_t;

    // ALU operation select, shared with ALU_Ctrl
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    // State entered from DECODE for a given opcode; anything unknown halts.
    function automatic state_t decode_target(input logic [6:0] opcode);
        state_t s;
        case (opcode)
            OP_R:               s = EXEC_R;
            OP_I:               s = EXEC_I;
            OP_LOAD, OP_STORE:  s = MEM_ADDR;
            OP_BRANCH:          s = BRANCH;
            default:            s = HALT;
        endcase
        return s;
    endfunction

    // True on the cycle an instruction leaves its final state.
    function automatic logic retires(input state_t s, input logic ack);
        return (s == ALU_WB) || (s == MEM_WB) || (s == BRANCH) ||
               ((s == MEM_WR) && ack);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath (slave).
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode_i;
    logic             zero_i;
    logic             dmem_ack_i;
    logic             PCWrite_o;
    logic             PCWriteCond_o;
    logic             PCSource_o;
    logic             IRWrite_o;
    logic             RegWrite_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             MemtoReg_o;
    logic             ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic [1:0]       ALUOp_o;
    logic             halt_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] instret_o;

    modport master (
        input  opcode_i, zero_i, dmem_ack_i,
        output PCWrite_o, PCWriteCond_o, PCSource_o, IRWrite_o, RegWrite_o,
               MemRead_o, MemWrite_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
               halt_o, cycle_cnt_o, instret_o
    );

    modport slave (
        output opcode_i, zero_i, dmem_ack_i,
        input  PCWrite_o, PCWriteCond_o, PCSource_o, IRWrite_o, RegWrite_o,
               MemRead_o, MemWrite_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
               halt_o, cycle_cnt_o, instret_o
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    // Count when enabled, hold at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through fetch/decode/execute/
// memory/write-back with Moore-decoded enables, stalls on the data-memory ack,
// halts on illegal opcodes and keeps cycle / retired-instruction counters.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    multicycle_ctrl_if.master    bus
);

    state_t state_reg;
    state_t state_next;
    logic   is_store_reg;
    logic   cycle_en;
    logic   retire_en;

    // The zero flag gates PCWriteCond in the datapath, not here
    logic   zero_unused;
    assign zero_unused = bus.zero_i;

    // State register; reset returns to FETCH regardless of any pending access
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Remember load vs store at decode so MEM_ADDR does not depend on the opcode later
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            is_store_reg <= 1'b0;
        end else if (state_reg == DECODE) begin
            is_store_reg <= (bus.opcode_i == OP_STORE);
        end
    end

    // Next-state logic; memory states wait for the ack
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:    state_next = DECODE;
            DECODE:   state_next = decode_target(bus.opcode_i);
            EXEC_R:   state_next = ALU_WB;
            EXEC_I:   state_next = ALU_WB;
            ALU_WB:   state_next = FETCH;
            MEM_ADDR: state_next = is_store_reg ? MEM_WR : MEM_RD;
            MEM_RD:   state_next = bus.dmem_ack_i ? MEM_WB : MEM_RD;
            MEM_WB:   state_next = FETCH;
            MEM_WR:   state_next = bus.dmem_ack_i ? FETCH : MEM_WR;
            BRANCH:   state_next = FETCH;
            HALT:     state_next = HALT;
            default:  state_next = HALT;
        endcase
    end

    // Moore output decode; everything idle unless the state asserts it
    always_comb begin
        bus.PCWrite_o     = 1'b0;
        bus.PCWriteCond_o = 1'b0;
        bus.PCSource_o    = 1'b0;
        bus.IRWrite_o     = 1'b0;
        bus.RegWrite_o    = 1'b0;
        bus.MemRead_o     = 1'b0;
        bus.MemWrite_o    = 1'b0;
        bus.MemtoReg_o    = 1'b0;
        bus.ALUSrcA_o     = 1'b0;
        bus.ALUSrcB_o     = SRCB_RT;
        bus.ALUOp_o       = ALUOP_ADD;
        bus.halt_o        = 1'b0;
        case (state_reg)
            FETCH: begin
                bus.IRWrite_o = 1'b1;
                bus.PCWrite_o = 1'b1;
                bus.ALUSrcB_o = SRCB_FOUR;
            end
            DECODE: begin
                bus.ALUSrcB_o = SRCB_IMM;
            end
            EXEC_R: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUOp_o   = ALUOP_FUNCT;
            end
            EXEC_I: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = SRCB_IMM;
                bus.ALUOp_o   = ALUOP_FUNCT;
            end
            ALU_WB: begin
                bus.RegWrite_o = 1'b1;
            end
            MEM_ADDR: begin
                bus.ALUSrcA_o = 1'b1;
                bus.ALUSrcB_o = SRCB_IMM;
            end
            MEM_RD: begin
                bus.MemRead_o = 1'b1;
            end
            MEM_WB: begin
                bus.RegWrite_o = 1'b1;
                bus.MemtoReg_o = 1'b1;
            end
            MEM_WR: begin
                bus.MemWrite_o = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA_o     = 1'b1;
                bus.ALUOp_o       = ALUOP_SUB;
                bus.PCWriteCond_o = 1'b1;
                bus.PCSource_o    = 1'b1;
            end
            HALT: begin
                bus.halt_o = 1'b1;
            end
            default: begin
                bus.halt_o = 1'b1;
            end
        endcase
    end

    assign cycle_en  = (state_reg != HALT);
    assign retire_en = retires(state_reg, bus.dmem_ack_i);

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk_i),
        .clr_n (nrst_i),
        .en    (cycle_en),
        .cnt   (bus.cycle_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_instret (
        .clk   (clk_i),
        .clr_n (nrst_i),
        .en    (retire_en),
        .cnt   (bus.instret_o)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class state by
// state with hand-computed expected enables, latencies and counter values.
module tb_multicycle_ctrl;

    logic clk;
    logic nrst;
    int   n_assert;
    int   n_fail;
    int   rd_cycles;
    int   wb_count;
    int   regw_count;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i  (clk),
        .nrst_i (nrst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; observe 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watchdog in case the clock or the sequence stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        nrst = 1'b0;
        bus.opcode_i   = 7'b0;
        bus.zero_i     = 1'b0;
        bus.dmem_ack_i = 1'b0;
        repeat (2) step();
        chk("rst0_irwrite", bus.IRWrite_o, 1);
        chk("rst0_cycle",   bus.cycle_cnt_o, 0);
        chk("rst0_halt",    bus.halt_o, 0);

        // Reset while a load is waiting in MEM_RD
        nrst = 1'b1;
        bus.opcode_i = 7'b0000011;
        step(); step(); step();
        chk("pre_rst_memread", bus.MemRead_o, 1);
        chk("pre_rst_cycle",   bus.cycle_cnt_o, 3);
        nrst = 1'b0;
        step();
        chk("rst_drop_memread", bus.MemRead_o, 0);
        step(); step();
        chk("rst_irwrite",  bus.IRWrite_o, 1);
        chk("rst_pcwrite",  bus.PCWrite_o, 1);
        chk("rst_srcb",     bus.ALUSrcB_o, 1);
        chk("rst_aluop",    bus.ALUOp_o, 0);
        chk("rst_regwrite", bus.RegWrite_o, 0);
        chk("rst_memread",  bus.MemRead_o, 0);
        chk("rst_memwrite", bus.MemWrite_o, 0);
        chk("rst_cycle",    bus.cycle_cnt_o, 0);
        chk("rst_instret",  bus.instret_o, 0);
        $display("reset mid-MEM_RD: done");

        // add: FETCH, DECODE, EXEC_R, ALU_WB
        nrst = 1'b1;
        bus.opcode_i = 7'b0110011;
        chk("add_c0_irwrite", bus.IRWrite_o, 1);
        step();
        chk("add_c1_irwrite", bus.IRWrite_o, 0);
        chk("add_c1_srca",    bus.ALUSrcA_o, 0);
        chk("add_c1_srcb",    bus.ALUSrcB_o, 2);
        step();
        chk("add_c2_aluop",   bus.ALUOp_o, 2);
        chk("add_c2_srca",    bus.ALUSrcA_o, 1);
        chk("add_c2_srcb",    bus.ALUSrcB_o, 0);
        chk("add_c2_regwrite", bus.RegWrite_o, 0);
        step();
        chk("add_c3_regwrite", bus.RegWrite_o, 1);
        chk("add_c3_memtoreg", bus.MemtoReg_o, 0);
        chk("add_c3_instret",  bus.instret_o, 0);
        step();
        chk("add_instret", bus.instret_o, 1);
        chk("add_cycle",   bus.cycle_cnt_o, 4);
        chk("add_fetch",   bus.IRWrite_o, 1);
        $display("add: instret=%0d cycles=%0d", bus.instret_o, bus.cycle_cnt_o);

        // load with ack after 3 wait cycles
        bus.opcode_i = 7'b0000011;
        regw_count = 0;
        step();
        regw_count += int'(bus.RegWrite_o);
        step();
        regw_count += int'(bus.RegWrite_o);
        chk("ld_addr_srca",  bus.ALUSrcA_o, 1);
        chk("ld_addr_srcb",  bus.ALUSrcB_o, 2);
        chk("ld_addr_aluop", bus.ALUOp_o, 0);
        step();
        rd_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            rd_cycles += int'(bus.MemRead_o);
            regw_count += int'(bus.RegWrite_o);
            chk("ld_rd_memread",  bus.MemRead_o, 1);
            chk("ld_rd_memwrite", bus.MemWrite_o, 0);
            bus.dmem_ack_i = (i == 3);
            step();
        end
        bus.dmem_ack_i = 1'b0;
        chk("ld_rd_cycles", rd_cycles, 4);
        chk("ld_wb_memread", bus.MemRead_o, 0);
        chk("ld_wb_memtoreg", bus.MemtoReg_o, 1);
        wb_count = int'(bus.RegWrite_o && bus.MemtoReg_o);
        regw_count += int'(bus.RegWrite_o);
        step();
        regw_count += int'(bus.RegWrite_o);
        chk("ld_wb_once",   wb_count, 1);
        chk("ld_regw_once", regw_count, 1);
        chk("ld_instret",   bus.instret_o, 2);
        chk("ld_cycle",     bus.cycle_cnt_o, 12);
        $display("load: instret=%0d cycles=%0d", bus.instret_o, bus.cycle_cnt_o);

        // store with immediate ack
        bus.opcode_i = 7'b0100011;
        regw_count = int'(bus.RegWrite_o);
        step();
        regw_count += int'(bus.RegWrite_o);
        step();
        regw_count += int'(bus.RegWrite_o);
        step();
        regw_count += int'(bus.RegWrite_o);
        chk("st_memwrite", bus.MemWrite_o, 1);
        chk("st_memread",  bus.MemRead_o, 0);
        bus.dmem_ack_i = 1'b1;
        step();
        bus.dmem_ack_i = 1'b0;
        regw_count += int'(bus.RegWrite_o);
        chk("st_memwrite_done", bus.MemWrite_o, 0);
        chk("st_no_regwrite", regw_count, 0);
        chk("st_instret", bus.instret_o, 3);
        chk("st_cycle",   bus.cycle_cnt_o, 16);
        $display("store: instret=%0d cycles=%0d", bus.instret_o, bus.cycle_cnt_o);

        // beq, taken then not taken: outputs identical, 3 cycles each
        bus.opcode_i = 7'b1100011;
        for (int z = 1; z >= 0; z--) begin
            bus.zero_i = z[0];
            step();
            step();
            chk("br_pcwritecond", bus.PCWriteCond_o, 1);
            chk("br_pcsource",    bus.PCSource_o, 1);
            chk("br_aluop",       bus.ALUOp_o, 1);
            chk("br_pcwrite",     bus.PCWrite_o, 0);
            chk("br_srcb",        bus.ALUSrcB_o, 0);
            step();
            chk("br_instret", bus.instret_o, 64'(5 - z));
            chk("br_cycle",   bus.cycle_cnt_o, 64'(22 - 3 * z));
            $display("beq zero=%0d: instret=%0d cycles=%0d", z, bus.instret_o, bus.cycle_cnt_o);
        end
        bus.zero_i = 1'b0;

        // I-type: FETCH, DECODE, EXEC_I, ALU_WB
        bus.opcode_i = 7'b0010011;
        step();
        step();
        chk("i_srcb",  bus.ALUSrcB_o, 2);
        chk("i_aluop", bus.ALUOp_o, 2);
        step();
        chk("i_regwrite", bus.RegWrite_o, 1);
        step();
        chk("i_instret", bus.instret_o, 6);
        chk("i_cycle",   bus.cycle_cnt_o, 26);
        $display("addi: instret=%0d cycles=%0d", bus.instret_o, bus.cycle_cnt_o);

        // Illegal opcode from a fresh reset
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        bus.opcode_i = 7'b1111111;
        chk("ill_c0_halt", bus.halt_o, 0);
        step();
        chk("ill_c1_halt", bus.halt_o, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("ill_halt",     bus.halt_o, 1);
            chk("ill_cycle",    bus.cycle_cnt_o, 2);
            chk("ill_instret",  bus.instret_o, 0);
            chk("ill_memread",  bus.MemRead_o, 0);
            chk("ill_memwrite", bus.MemWrite_o, 0);
            chk("ill_pcwrite",  bus.PCWrite_o, 0);
            chk("ill_irwrite",  bus.IRWrite_o, 0);
            bus.dmem_ack_i = i[0];
            step();
        end
        bus.dmem_ack_i = 1'b0;
        $display("illegal: halt=%0d cycles=%0d", bus.halt_o, bus.cycle_cnt_o);

        // Reset leaves HALT
        nrst = 1'b0;
        step();
        chk("unhalt_halt",  bus.halt_o, 0);
        chk("unhalt_cycle", bus.cycle_cnt_o, 0);
        chk("unhalt_fetch", bus.IRWrite_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
